// File: rtl/rom_read_arbiter.sv
// rom_read_arbiter: round-robin sharing of a negedge-CS coefficient ROM
// between two requesters; fixed CS strobe, registered capture and ack.
module rom_read_arbiter #(
  parameter int ADDR_W   = 4,
  parameter int DATA_W   = 16,
  parameter int WAIT_CYC = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic              req1,
  input  logic [ADDR_W-1:0] addr1,
  output logic              ack0,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic [ADDR_W-1:0] rom_addr,
  output logic              rom_cs,
  input  logic [DATA_W-1:0] rom_data
);

  localparam int CNT_W = (WAIT_CYC > 1) ? $clog2(WAIT_CYC) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WAIT_CYC - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_SETUP  = 3'd1;
  localparam logic [2:0] S_STROBE = 3'd2;
  localparam logic [2:0] S_HOLD   = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  logic [2:0]        r_state;
  logic              r_gnt;
  logic              r_last;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_ack0;
  logic              r_ack1;
  logic              r_busy;
  logic              r_cs;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_rdata;

  logic w_any;
  logic w_gnt;

  assign w_any = req0 | req1;
  // On a tie the requester not served last wins; otherwise the sole one.
  assign w_gnt = (req0 & req1) ? ~r_last : req1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_gnt   <= 1'b0;
      r_last  <= 1'b1;
      r_cnt   <= '0;
      r_ack0  <= 1'b0;
      r_ack1  <= 1'b0;
      r_busy  <= 1'b0;
      r_cs    <= 1'b1;
      r_addr  <= '0;
      r_rdata <= '0;
    end else begin
      unique case (1'b1)
        (r_state == S_IDLE): begin
          if (w_any) begin
            r_gnt   <= w_gnt;
            r_addr  <= w_gnt ? addr1 : addr0;
            r_busy  <= 1'b1;
            r_state <= S_SETUP;
          end
        end
        (r_state == S_SETUP): begin
          r_cs    <= 1'b0;
          r_state <= S_STROBE;
        end
        (r_state == S_STROBE): begin
          r_cnt   <= '0;
          r_state <= S_HOLD;
        end
        (r_state == S_HOLD): begin
          if (r_cnt == LAST) begin
            r_rdata <= rom_data;
            r_ack0  <= ~r_gnt;
            r_ack1  <= r_gnt;
            r_last  <= r_gnt;
            r_cs    <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        (r_state == S_DONE): begin
          r_ack0  <= 1'b0;
          r_ack1  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_ack0  <= 1'b0;
          r_ack1  <= 1'b0;
          r_busy  <= 1'b0;
          r_cs    <= 1'b1;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign ack0     = r_ack0;
  assign ack1     = r_ack1;
  assign rdata    = r_rdata;
  assign busy     = r_busy;
  assign rom_addr = r_addr;
  assign rom_cs   = r_cs;

endmodule

// File: tb/tb_rom_read_arbiter.sv
// Bench for rom_read_arbiter: two builds (WAIT_CYC 1 and 3) share stimulus;
// a transaction-timing model predicts acks, CS window, busy and data.
module tb_rom_read_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic req0 = 1'b0;
  logic req1 = 1'b0;
  logic [3:0] addr0 = '0;
  logic [3:0] addr1 = '0;

  logic [1:0]  ack0_s;
  logic [1:0]  ack1_s;
  logic [1:0]  busy_s;
  logic [1:0]  cs_s;
  logic [15:0] rdata_s [2];
  logic [3:0]  raddr_s [2];
  logic [15:0] rdat0 = '0;
  logic [15:0] rdat1 = '0;

  logic [15:0] rom_tab [16];

  int n_chk = 0;
  int n_bad = 0;
  int cyc = 0;
  int wv [2];
  int acc [2];
  bit last [2];
  bit who [2];
  logic [15:0] pdat [2];
  logic [15:0] edat [2];
  logic [3:0]  eaddr [2];
  int lc [2];
  logic [15:0] ld1;
  int wq0[$];
  int dq0[$];
  int cq0[$];
  bit hold0 = 1'b0;
  bit hold1 = 1'b0;

  always #5 clk = ~clk;

  rom_read_arbiter #(.ADDR_W(4), .DATA_W(16), .WAIT_CYC(1)) u_dut0 (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .addr0(addr0), .req1(req1), .addr1(addr1),
    .ack0(ack0_s[0]), .ack1(ack1_s[0]), .rdata(rdata_s[0]),
    .busy(busy_s[0]), .rom_addr(raddr_s[0]), .rom_cs(cs_s[0]),
    .rom_data(rdat0)
  );

  rom_read_arbiter #(.ADDR_W(4), .DATA_W(16), .WAIT_CYC(3)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .addr0(addr0), .req1(req1), .addr1(addr1),
    .ack0(ack0_s[1]), .ack1(ack1_s[1]), .rdata(rdata_s[1]),
    .busy(busy_s[1]), .rom_addr(raddr_s[1]), .rom_cs(cs_s[1]),
    .rom_data(rdat1)
  );

  // ROM: the falling CS edge launches the read of the current address
  always @(negedge cs_s[0]) rdat0 = rom_tab[raddr_s[0]];
  always @(negedge cs_s[1]) rdat1 = rom_tab[raddr_s[1]];

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      acc[k] = -100;
      last[k] = 1'b1;
      who[k] = 1'b0;
      edat[k] = '0;
      eaddr[k] = '0;
      pdat[k] = '0;
    end
  endtask

  task automatic clr();
    wq0.delete();
    dq0.delete();
    cq0.delete();
    lc[0] = 0;
    lc[1] = 0;
    ld1 = 16'hdead;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("rst_cs[%0d]", k), cs_s[k], 1);
      chk($sformatf("rst_busy[%0d]", k), busy_s[k], 0);
      chk($sformatf("rst_ack[%0d]", k), {ack1_s[k], ack0_s[k]}, 0);
      chk($sformatf("rst_rdata[%0d]", k), rdata_s[k], 0);
      chk($sformatf("rst_addr[%0d]", k), raddr_s[k], 0);
    end
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic step();
    bit xa;
    @(posedge clk);
    cyc++;
    for (int k = 0; k < 2; k++) begin
      if (cyc == acc[k] + 2 + wv[k]) edat[k] = pdat[k];
      if (cyc >= acc[k] + 4 + wv[k] && (req0 || req1)) begin
        who[k] = (req0 && req1) ? !last[k] : req1;
        last[k] = who[k];
        acc[k] = cyc;
        eaddr[k] = who[k] ? addr1 : addr0;
        pdat[k] = rom_tab[eaddr[k]];
      end
    end
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      xa = (cyc == acc[k] + 2 + wv[k]);
      chk($sformatf("ack0[%0d]", k), ack0_s[k], xa && !who[k]);
      chk($sformatf("ack1[%0d]", k), ack1_s[k], xa && who[k]);
      chk($sformatf("busy[%0d]", k), busy_s[k],
          cyc >= acc[k] && cyc <= acc[k] + 2 + wv[k]);
      chk($sformatf("cs[%0d]", k), cs_s[k],
          !(cyc >= acc[k] + 1 && cyc <= acc[k] + 1 + wv[k]));
      chk($sformatf("rdata[%0d]", k), rdata_s[k], edat[k]);
      chk($sformatf("raddr[%0d]", k), raddr_s[k], eaddr[k]);
      if (cs_s[k] === 1'b0) lc[k]++;
    end
    if (ack0_s[0] || ack1_s[0]) begin
      wq0.push_back(int'(ack1_s[0]));
      dq0.push_back(int'(rdata_s[0]));
      cq0.push_back(cyc);
    end
    if (ack0_s[1] || ack1_s[1]) ld1 = rdata_s[1];
    if (ack0_s[0] && !hold0) req0 = 1'b0;
    if (ack1_s[0] && !hold1) req1 = 1'b0;
  endtask

  function automatic bit idle_all();
    return cyc >= acc[0] + 3 + wv[0] && cyc >= acc[1] + 3 + wv[1];
  endfunction

  task automatic drain();
    int b = 0;
    while ((!idle_all() || req0 || req1) && b < 100) begin
      step();
      b++;
    end
    if (b >= 100) chk("drain_timeout", 1, 0);
  endtask

  initial begin
    wv[0] = 1;
    wv[1] = 3;
    for (int i = 0; i < 16; i++) rom_tab[i] = 16'(i * 16'h1111 ^ 16'h00a5);
    rom_tab[0]  = 16'h5601;
    rom_tab[1]  = 16'h3401;
    rom_tab[3]  = 16'h0ac1;
    rom_tab[8]  = 16'h4801;
    rom_tab[12] = 16'h1c01;
    rom_tab[15] = 16'h5401;
    model_reset();
    clr();
    #2;
    do_reset();

    // single read, addr 3
    clr();
    req0 = 1'b1;
    addr0 = 4'd3;
    drain();
    chk("t1_nack", wq0.size(), 1);
    if (wq0.size() == 1) begin
      chk("t1_who", wq0[0], 0);
      chk("t1_data", dq0[0], 16'h0ac1);
    end
    chk("t1_cslow0", lc[0], 2);
    chk("t1_data_w3", ld1, 16'h0ac1);
    chk("t1_cslow1", lc[1], 4);

    // simultaneous requests after reset: requester 0 first
    do_reset();
    clr();
    req0 = 1'b1;
    addr0 = 4'd0;
    req1 = 1'b1;
    addr1 = 4'd1;
    drain();
    chk("t2_nack", wq0.size(), 2);
    if (wq0.size() == 2) begin
      chk("t2_who0", wq0[0], 0);
      chk("t2_data0", dq0[0], 16'h5601);
      chk("t2_who1", wq0[1], 1);
      chk("t2_data1", dq0[1], 16'h3401);
    end

    // both held: fair alternation, 5-cycle spacing
    clr();
    hold0 = 1'b1;
    hold1 = 1'b1;
    req0 = 1'b1;
    addr0 = 4'd2;
    req1 = 1'b1;
    addr1 = 4'd9;
    for (int b = 0; b < 100 && wq0.size() < 4; b++) step();
    hold0 = 1'b0;
    hold1 = 1'b0;
    req0 = 1'b0;
    req1 = 1'b0;
    chk("t3_nack", wq0.size() >= 4, 1);
    if (wq0.size() >= 4) begin
      for (int i = 0; i < 4; i++) chk("t3_who", wq0[i], i % 2);
      for (int i = 0; i < 3; i++) chk("t3_gap", cq0[i+1] - cq0[i], 5);
    end
    drain();

    // request dropped and address changed after grant
    clr();
    req1 = 1'b1;
    addr1 = 4'd15;
    step();
    step();
    req1 = 1'b0;
    addr1 = 4'd4;
    drain();
    chk("t4_nack", wq0.size(), 1);
    if (wq0.size() == 1) begin
      chk("t4_who", wq0[0], 1);
      chk("t4_data", dq0[0], 16'h5401);
    end
    clr();
    req0 = 1'b1;
    addr0 = 4'd5;
    drain();
    chk("t4b_nack", wq0.size(), 1);
    if (wq0.size() == 1) chk("t4b_data", dq0[0], rom_tab[5]);

    // reset during HOLD, request still pending afterwards
    clr();
    req0 = 1'b1;
    addr0 = 4'd8;
    step();
    step();
    step();
    chk("t5_noack", wq0.size(), 0);
    do_reset();
    drain();
    chk("t5_nack", wq0.size(), 1);
    if (wq0.size() == 1) chk("t5_data", dq0[0], 16'h4801);
    chk("t5_data_w3", ld1, 16'h4801);

    // longer hold build, addr 12
    clr();
    req0 = 1'b1;
    addr0 = 4'd12;
    drain();
    chk("t6_data_w3", ld1, 16'h1c01);
    chk("t6_cslow1", lc[1], 4);
    chk("t6_cslow0", lc[0], 2);

    // random traffic
    for (int n = 0; n < 400; n++) begin
      step();
      if (!req0 && $urandom_range(3) == 0) begin
        req0 = 1'b1;
        addr0 = 4'($urandom);
        hold0 = ($urandom_range(3) == 0);
      end else if (req0 && $urandom_range(15) == 0) begin
        req0 = 1'b0;
        addr0 = 4'($urandom);
      end
      if (!req1 && $urandom_range(3) == 0) begin
        req1 = 1'b1;
        addr1 = 4'($urandom);
        hold1 = ($urandom_range(3) == 0);
      end else if (req1 && $urandom_range(15) == 0) begin
        req1 = 1'b0;
        addr1 = 4'($urandom);
      end
      if (n == 200) begin
        @(posedge clk);
        #2;
        do_reset();
      end
    end
    hold0 = 1'b0;
    hold1 = 1'b0;
    req0 = 1'b0;
    req1 = 1'b0;
    drain();

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
